// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and baud divider helper
// for the UART transmit/receive blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  // Tick pulses per bit, rounded to nearest.
  function automatic int baud_div(input int tick_hz, input int baud);
    return (tick_hz + (baud / 32'sd2)) / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    if (mode == PAR_ODD) begin
      p = ~(^data);
    end else begin
      p = ^data;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts enabled tick pulses and flags the DIV-th one as the
// end of the current bit.
module uart_bit_timer #(
  parameter int DIV = 32'sd104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic bit_done
);

  localparam int            CW   = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'sd1);

  logic [CW-1:0] cnt_r;

  assign bit_done = tick && (cnt_r == LAST);

  // Tick counter; clear wins over a coincident tick so that tick is not counted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= '0;
    end else if (tick) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: byte-wide UART transmitter paced by an external tick enable,
// with a valid/ready byte handshake and registered line outputs.
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int TICK_HZ   = 32'sd1_000_000,
  parameter int BAUD      = 32'sd9600,
  parameter int PARITY    = 32'sd0,
  parameter int STOP_BITS = 32'sd1
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic       iTICK,
  input  logic [7:0] iDATA,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oUART_TXD,
  output logic       oBUSY
);

  localparam int   DIV       = baud_div(TICK_HZ, BAUD);
  localparam logic STOP_LAST = (STOP_BITS == 32'sd2) ? 1'b1 : 1'b0;

  if (DIV < 32'sd2) begin : g_div_check
    $error("uart_tx_tick: baud divider must be at least 2");
  end
  if ((STOP_BITS != 32'sd1) && (STOP_BITS != 32'sd2)) begin : g_stop_check
    $error("uart_tx_tick: STOP_BITS must be 1 or 2");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : g_par_check
    $error("uart_tx_tick: PARITY must be 0, 1 or 2");
  end

  tx_state_t  state_r, state_s;
  logic [7:0] shift_r, shift_s;
  logic [2:0] idx_r, idx_s;
  logic       stop_r, stop_s;
  logic       par_r, par_s;
  logic       txd_r, txd_s;
  logic       ready_r, ready_s;
  logic       busy_r, busy_s;
  logic       timer_clear_s;
  logic       timer_tick_s;
  logic       bit_done_s;

  // Ticks only advance the bit timer while a frame is in flight.
  assign timer_tick_s = iTICK && (state_r != IDLE);

  uart_bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk     (iCLK_50),
    .rst     (iRST),
    .clear   (timer_clear_s),
    .tick    (timer_tick_s),
    .bit_done(bit_done_s)
  );

  // Next-state, shift register and next line level.
  always_comb begin
    state_s       = state_r;
    shift_s       = shift_r;
    idx_s         = idx_r;
    stop_s        = stop_r;
    par_s         = par_r;
    txd_s         = txd_r;
    ready_s       = ready_r;
    busy_s        = busy_r;
    timer_clear_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (iVALID && ready_r) begin
          state_s       = START;
          shift_s       = iDATA;
          idx_s         = 3'd0;
          stop_s        = 1'b0;
          txd_s         = 1'b0;
          ready_s       = 1'b0;
          busy_s        = 1'b1;
          timer_clear_s = 1'b1;
        end else begin
          txd_s   = 1'b1;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_s = DATA;
          par_s   = parity_bit(shift_r, PARITY);
          txd_s   = shift_r[0];
          shift_s = {1'b0, shift_r[7:1]};
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (idx_r != 3'd7) begin
            txd_s   = shift_r[0];
            shift_s = {1'b0, shift_r[7:1]};
            idx_s   = idx_r + 3'd1;
          end else if (PARITY != PAR_NONE) begin
            state_s = uart_pkg::PARITY;
            txd_s   = par_r;
          end else begin
            state_s = STOP;
            txd_s   = 1'b1;
            stop_s  = 1'b0;
          end
        end else begin
          state_s = DATA;
        end
      end
      uart_pkg::PARITY: begin
        if (bit_done_s) begin
          state_s = STOP;
          txd_s   = 1'b1;
          stop_s  = 1'b0;
        end else begin
          state_s = uart_pkg::PARITY;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          if (stop_r == STOP_LAST) begin
            state_s = IDLE;
            txd_s   = 1'b1;
            ready_s = 1'b1;
            busy_s  = 1'b0;
          end else begin
            stop_s = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        txd_s   = 1'b1;
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_r <= IDLE;
      shift_r <= 8'h00;
      idx_r   <= 3'd0;
      stop_r  <= 1'b0;
      par_r   <= 1'b0;
      txd_r   <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      idx_r   <= idx_s;
      stop_r  <= stop_s;
      par_r   <= par_s;
      txd_r   <= txd_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  assign oUART_TXD = txd_r;
  assign oREADY    = ready_r;
  assign oBUSY     = busy_r;

endmodule

// File: tb/tb_uart_tx_tick.sv
// tb_uart_tx_tick: randomized bench comparing the serial line of three
// transmitter configurations against a frame-level model.
module tb_uart_tx_tick;

  localparam int DIV     = 104;
  localparam int GAP     = 3;
  localparam int MAX_CLK = 20000;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       valid [3];
  logic [7:0] data  [3];
  logic       txd   [3];
  logic       ready [3];
  logic       busy  [3];

  int   n_checks;
  int   n_fail;
  int   tick_cd;
  bit   irregular;
  logic tick_last;

  uart_tx_tick dut0 (
    .iCLK_50(clk), .iRST(rst), .iTICK(tick), .iDATA(data[0]), .iVALID(valid[0]),
    .oREADY(ready[0]), .oUART_TXD(txd[0]), .oBUSY(busy[0])
  );

  uart_tx_tick #(.PARITY(2)) dut1 (
    .iCLK_50(clk), .iRST(rst), .iTICK(tick), .iDATA(data[1]), .iVALID(valid[1]),
    .oREADY(ready[1]), .oUART_TXD(txd[1]), .oBUSY(busy[1])
  );

  uart_tx_tick #(.STOP_BITS(2)) dut2 (
    .iCLK_50(clk), .iRST(rst), .iTICK(tick), .iDATA(data[2]), .iVALID(valid[2]),
    .oREADY(ready[2]), .oUART_TXD(txd[2]), .oBUSY(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame as a bit list: start, data LSB first, optional parity, stops.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int par,
                                              input int stops, output int nbits);
    logic [15:0] f;
    int k;
    f = '0;
    k = 0;
    f[k] = 1'b0; k++;
    for (int i = 0; i < 8; i++) begin f[k] = d[i]; k++; end
    if (par == 1) begin f[k] = (($countones(d) % 2) == 0); k++; end
    else if (par == 2) begin f[k] = (($countones(d) % 2) == 1); k++; end
    for (int i = 0; i < stops; i++) begin f[k] = 1'b1; k++; end
    nbits = k;
    return f;
  endfunction

  task automatic step(input bit force_tick);
    if (force_tick) begin
      tick = 1'b1;
    end else if (tick_cd == 0) begin
      tick = 1'b1;
      tick_cd = irregular ? $urandom_range(7, 1) : GAP - 1;
    end else begin
      tick = 1'b0;
      tick_cd--;
    end
    tick_last = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit force_tick);
    valid[sel] = 1'b1;
    data[sel]  = d;
    step(force_tick);
    valid[sel] = 1'b0;
    data[sel]  = 8'($urandom);
  endtask

  // Records the line after each counted tick until ready rises (or abort/timeout),
  // then slices it into DIV-tick bits. Observation only.
  task automatic capture(input int sel, input int poke_tick, input int abort_tick,
                         output logic [15:0] bits_o, output int nbits_o, output int ticks_o,
                         output int unstable_o, output logic ready_poke_o, output bit timeout_o);
    logic line_q [$];
    int   n, clk_cnt, lim;
    bit   poking, poked;
    line_q = {};
    n = 0; clk_cnt = 0; poked = 1'b0; timeout_o = 1'b0; ready_poke_o = 1'bx; ticks_o = -1;
    bits_o = '0; nbits_o = 0; unstable_o = 0;
    line_q.push_back(txd[sel]);
    forever begin
      poking = (n == poke_tick) && !poked;
      if (poking) begin valid[sel] = 1'b1; data[sel] = 8'hFF; end
      step(1'b0);
      if (poking) begin valid[sel] = 1'b0; poked = 1'b1; ready_poke_o = ready[sel]; end
      clk_cnt++;
      if (tick_last) begin n++; line_q.push_back(txd[sel]); end
      if (ready[sel] === 1'b1) begin ticks_o = n; break; end
      if (n == abort_tick) break;
      if (clk_cnt >= MAX_CLK) begin timeout_o = 1'b1; break; end
    end
    lim = (ticks_o >= 0) ? ticks_o : line_q.size();
    for (int i = 0; i < lim; i++)
      if (line_q[i] !== line_q[(i / DIV) * DIV]) unstable_o++;
    if (ticks_o >= 0) begin
      nbits_o = ticks_o / DIV;
      for (int i = 0; i < nbits_o && i < 16; i++) bits_o[i] = line_q[i * DIV];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step(1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (txd[i] !== 1'b1) begin n_fail++; $display("FAIL reset_txd[%0d]: got %b expected 1", i, txd[i]); end
      n_checks++;
      if (ready[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready[i]); end
      n_checks++;
      if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy[i]); end
    end
    rst = 1'b0;
    step(1'b0);
  endtask

  // Shared body for a plain single-frame send-and-check on one instance.
  task automatic test_frames(input int sel, input int par, input int stops, input logic [7:0] first);
    logic [7:0]  b;
    logic [15:0] bits, exp;
    int          nb, enb, tk, uns;
    logic        rp;
    bit          to;
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? first : 8'($urandom);
      send(sel, b, 1'b0);
      n_checks++;
      if ({txd[sel], ready[sel], busy[sel]} !== 3'b001) begin
        n_fail++; $display("FAIL accept_edge[%0d] byte %h: got txd/ready/busy %b expected 001", sel, b, {txd[sel], ready[sel], busy[sel]});
      end
      capture(sel, -1, -1, bits, nb, tk, uns, rp, to);
      exp = model_frame(b, par, stops, enb);
      n_checks++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL frame_timeout[%0d]: got %b expected 0", sel, to); end
      n_checks++;
      if (bits !== exp) begin n_fail++; $display("FAIL frame_bits[%0d] byte %h: got %h expected %h", sel, b, bits, exp); end
      n_checks++;
      if (tk !== enb * DIV) begin n_fail++; $display("FAIL ready_low_ticks[%0d]: got %0d expected %0d", sel, tk, enb * DIV); end
      n_checks++;
      if (uns !== 0) begin n_fail++; $display("FAIL bit_length[%0d]: got %0d off-phase ticks expected 0", sel, uns); end
      n_checks++;
      if ({txd[sel], ready[sel], busy[sel]} !== 3'b110) begin
        n_fail++; $display("FAIL frame_end[%0d]: got txd/ready/busy %b expected 110", sel, {txd[sel], ready[sel], busy[sel]});
      end
      repeat (5) step(1'b0);
    end
  endtask

  task automatic test_single();
    test_frames(0, 0, 1, 8'h55);
  endtask

  task automatic test_even_parity();
    test_frames(1, 2, 2 - 1, 8'h07);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  b [2];
    logic [15:0] bits, exp;
    int          nb, enb, tk, uns;
    logic        rp;
    bit          to;
    b[0] = 8'hA3;
    b[1] = 8'h3C;
    valid[2] = 1'b1;
    data[2]  = b[0];
    step(1'b0);
    for (int t = 0; t < 2; t++) begin
      n_checks++;
      if ({txd[2], ready[2], busy[2]} !== 3'b001) begin
        n_fail++; $display("FAIL b2b_accept%0d: got txd/ready/busy %b expected 001", t, {txd[2], ready[2], busy[2]});
      end
      capture(2, -1, -1, bits, nb, tk, uns, rp, to);
      exp = model_frame(b[t], 0, 2, enb);
      n_checks++;
      if (bits !== exp || to !== 1'b0) begin n_fail++; $display("FAIL b2b_bits%0d: got %h expected %h (timeout %b)", t, bits, exp, to); end
      n_checks++;
      if (tk !== enb * DIV || uns !== 0) begin
        n_fail++; $display("FAIL b2b_length%0d: got %0d ticks/%0d off-phase expected %0d/0", t, tk, uns, enb * DIV);
      end
      n_checks++;
      if ({txd[2], ready[2], busy[2]} !== 3'b110) begin
        n_fail++; $display("FAIL b2b_gap%0d: got txd/ready/busy %b expected 110", t, {txd[2], ready[2], busy[2]});
      end
      if (t == 0) begin
        data[2] = b[1];
        step(1'b0);
      end else begin
        valid[2] = 1'b0;
      end
    end
    repeat (5) step(1'b0);
  endtask

  task automatic test_handshake();
    logic [15:0] bits, exp;
    int          nb, enb, tk, uns, viol;
    logic        rp;
    bit          to;
    send(0, 8'h00, 1'b0);
    capture(0, 300, -1, bits, nb, tk, uns, rp, to);
    exp = model_frame(8'h00, 0, 1, enb);
    n_checks++;
    if (rp !== 1'b0) begin n_fail++; $display("FAIL hs_ready_mid_frame: got %b expected 0", rp); end
    n_checks++;
    if (bits !== exp || to !== 1'b0) begin n_fail++; $display("FAIL hs_bits: got %h expected %h (timeout %b)", bits, exp, to); end
    n_checks++;
    if (tk !== enb * DIV || uns !== 0) begin
      n_fail++; $display("FAIL hs_length: got %0d ticks/%0d off-phase expected %0d/0", tk, uns, enb * DIV);
    end
    viol = 0;
    repeat (400) begin
      step(1'b0);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL hs_no_queued_frame: got %0d active cycles expected 0", viol); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b;
    logic [15:0] bits, exp;
    int          nb, enb, tk, uns;
    logic        rp;
    bit          to;
    b = 8'($urandom);
    send(0, b, 1'b0);
    capture(0, -1, 4 * DIV + 50, bits, nb, tk, uns, rp, to);
    n_checks++;
    if (txd[0] !== b[3] || to !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data3: got %b expected %b (timeout %b)", txd[0], b[3], to); end
    rst = 1'b1;
    step(1'b0);
    n_checks++;
    if ({txd[0], ready[0], busy[0]} !== 3'b110) begin
      n_fail++; $display("FAIL rst_mid_abort: got txd/ready/busy %b expected 110", {txd[0], ready[0], busy[0]});
    end
    rst = 1'b0;
    repeat (3) step(1'b0);
    b = 8'($urandom);
    send(0, b, 1'b0);
    capture(0, -1, -1, bits, nb, tk, uns, rp, to);
    exp = model_frame(b, 0, 1, enb);
    n_checks++;
    if (bits !== exp || to !== 1'b0) begin n_fail++; $display("FAIL rst_mid_next_bits: got %h expected %h (timeout %b)", bits, exp, to); end
    n_checks++;
    if (tk !== enb * DIV || uns !== 0) begin
      n_fail++; $display("FAIL rst_mid_next_length: got %0d ticks/%0d off-phase expected %0d/0", tk, uns, enb * DIV);
    end
  endtask

  task automatic test_irregular();
    logic [7:0]  b;
    logic [15:0] bits, exp;
    int          nb, enb, tk, uns, viol;
    logic        rp;
    bit          to;
    irregular = 1'b1;
    viol = 0;
    repeat (400) begin
      step(1'b0);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) viol++;
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL idle_tick_activity: got %0d active cycles expected 0", viol); end
    b = 8'($urandom);
    send(0, b, 1'b1);
    n_checks++;
    if ({txd[0], ready[0], busy[0]} !== 3'b001) begin
      n_fail++; $display("FAIL irr_accept: got txd/ready/busy %b expected 001", {txd[0], ready[0], busy[0]});
    end
    capture(0, -1, -1, bits, nb, tk, uns, rp, to);
    exp = model_frame(b, 0, 1, enb);
    n_checks++;
    if (bits !== exp || to !== 1'b0) begin n_fail++; $display("FAIL irr_bits: got %h expected %h (timeout %b)", bits, exp, to); end
    n_checks++;
    if (tk !== enb * DIV || uns !== 0) begin
      n_fail++; $display("FAIL irr_length: got %0d ticks/%0d off-phase expected %0d/0", tk, uns, enb * DIV);
    end
    irregular = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; tick_cd = 0; irregular = 1'b0; tick_last = 1'b0;
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < 3; i++) begin valid[i] = 1'b0; data[i] = 8'h00; end
    test_reset();
    test_single();
    test_even_parity();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    test_irregular();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
